// File: rtl/fp_mul_result_buffer.sv
// Registered result FIFO behind the floating-point multiplier, with sticky exception flags.
// Optional per-flag saturating event counters are enabled by defining FP_MUL_FLAG_COUNTERS_EN.
module fp_mul_result_buffer #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int DEPTH          = 4,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  in_result,
  input  logic                                    in_underflow,
  input  logic                                    in_overflow,
  input  logic                                    in_invalid,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  out_result,
  output logic [2:0]                              out_flags,
  output logic [2:0]                              sticky_flags,
  input  logic                                    flags_clear,
  output logic [$clog2(DEPTH):0]                  level
`ifdef FP_MUL_FLAG_COUNTERS_EN
  ,
  output logic [COUNT_WIDTH-1:0]                  underflow_count,
  output logic [COUNT_WIDTH-1:0]                  overflow_count,
  output logic [COUNT_WIDTH-1:0]                  invalid_count
`endif
);

  localparam int W  = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Each entry is {flags[2:0], result[W-1:0]}; contents are never reset.
  logic [W+2:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]    sticky_q, sticky_d;
  logic [PW-1:0] level_w;
  logic [2:0]    in_flags;
  logic [W+2:0]  head;
  logic          push;
  logic          pop;

  assign in_flags = {in_invalid, in_overflow, in_underflow};
  // Pointers carry one extra bit so full and empty differ; wrap is modulo 2*DEPTH.
  assign level_w  = wr_ptr_q - rd_ptr_q;
  assign in_ready = (level_w != PW'(DEPTH));
  assign out_valid = (level_w != '0);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    sticky_d = (flags_clear ? 3'b000 : sticky_q) | (push ? in_flags : 3'b000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sticky_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sticky_q <= sticky_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_flags, in_result};
    end
  end

  // Head is read only from registered state, so a push is never visible in its own cycle.
  assign out_result   = out_valid ? head[W-1:0] : '0;
  assign out_flags    = out_valid ? head[W+2:W] : '0;
  assign sticky_flags = sticky_q;
  assign level        = level_w;

`ifdef FP_MUL_FLAG_COUNTERS_EN
  logic [COUNT_WIDTH-1:0] cnt_q [3];
  logic [COUNT_WIDTH-1:0] cnt_d [3];

  // Index order matches in_flags: 0 underflow, 1 overflow, 2 invalid.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = flags_clear ? '0 : cnt_q[i];
      if (push && in_flags[i] && (cnt_d[i] != '1)) begin
        cnt_d[i] = cnt_d[i] + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign underflow_count = cnt_q[0];
  assign overflow_count  = cnt_q[1];
  assign invalid_count   = cnt_q[2];
`endif

endmodule

// File: tb/tb_fp_mul_result_buffer.sv
// Bench for fp_mul_result_buffer: directed plan steps followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_fp_mul_result_buffer;

  localparam int EW    = 8;
  localparam int MW    = 23;
  localparam int W     = EW + MW + 1;
  localparam int DEPTH = 4;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_result = '0;
  logic          in_underflow = 1'b0;
  logic          in_overflow = 1'b0;
  logic          in_invalid = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_result;
  logic [2:0]    out_flags;
  logic [2:0]    sticky_flags;
  logic          flags_clear = 1'b0;
  logic [$clog2(DEPTH):0] level;
`ifdef FP_MUL_FLAG_COUNTERS_EN
  logic [CW-1:0] underflow_count;
  logic [CW-1:0] overflow_count;
  logic [CW-1:0] invalid_count;
`endif

  int tests = 0;
  int failures = 0;

  // Reference model: queue of {flags, word}, sticky OR, saturating counts.
  logic [W+2:0] q_m[$];
  logic [2:0]   sticky_m = 3'b000;
  int           cnt_m[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  fp_mul_result_buffer #(
    .EXPONENT_WIDTH(EW),
    .MANTISSA_WIDTH(MW),
    .DEPTH(DEPTH),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_result(in_result),
    .in_underflow(in_underflow),
    .in_overflow(in_overflow),
    .in_invalid(in_invalid),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_flags(out_flags),
    .sticky_flags(sticky_flags),
    .flags_clear(flags_clear),
    .level(level)
`ifdef FP_MUL_FLAG_COUNTERS_EN
    ,
    .underflow_count(underflow_count),
    .overflow_count(overflow_count),
    .invalid_count(invalid_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int n;
    n = q_m.size();
    check("level", 64'(level), 64'(n));
    check("in_ready", 64'(in_ready), 64'(n != DEPTH));
    check("out_valid", 64'(out_valid), 64'(n != 0));
    check("out_result", 64'(out_result), (n != 0) ? 64'(q_m[0][W-1:0]) : 64'd0);
    check("out_flags", 64'(out_flags), (n != 0) ? 64'(q_m[0][W+2:W]) : 64'd0);
    check("sticky", 64'(sticky_flags), 64'(sticky_m));
`ifdef FP_MUL_FLAG_COUNTERS_EN
    check("underflow_count", 64'(underflow_count), 64'(cnt_m[0]));
    check("overflow_count", 64'(overflow_count), 64'(cnt_m[1]));
    check("invalid_count", 64'(invalid_count), 64'(cnt_m[2]));
`endif
  endtask

  // One clock cycle: drive inputs, check outputs of the current state, advance model.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic [2:0] f,
                     input logic r, input logic clr, input logic rs);
    logic push_m;
    logic pop_m;
    in_valid = v;
    in_result = d;
    in_invalid = f[2];
    in_overflow = f[1];
    in_underflow = f[0];
    out_ready = r;
    flags_clear = clr;
    rst = rs;
    #1;
    check_model();
    $display("[TB] t=%0t v=%0b d=%h f=%b r=%0b clr=%0b rst=%0b level=%0d out_valid=%0b out=%h sticky=%b",
             $time, v, d, f, r, clr, rs, level, out_valid, out_result, sticky_flags);
    if (rs) begin
      q_m.delete();
      sticky_m = 3'b000;
      for (int i = 0; i < 3; i++) cnt_m[i] = 0;
    end else begin
      push_m = v && (q_m.size() < DEPTH);
      pop_m = r && (q_m.size() > 0);
      sticky_m = (clr ? 3'b000 : sticky_m) | (push_m ? f : 3'b000);
      for (int i = 0; i < 3; i++) begin
        if (clr) cnt_m[i] = 0;
        if (push_m && f[i] && cnt_m[i] < CMAX) cnt_m[i]++;
      end
      if (pop_m) void'(q_m.pop_front());
      if (push_m) q_m.push_back({f, d});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q_m.size() > 0; i++) cyc(1'b0, '0, 3'b000, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and idle.
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0);

    // Single push; no same-cycle output, visible next cycle.
    cyc(1'b1, 32'h3F800000, 3'b000, 1'b0, 1'b0, 1'b0);
    check("first_out", 64'(out_result), 64'h3F800000);
    check("first_level", 64'(level), 64'd1);

    // Fill to full, hold a rejected word, then free one slot.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h3F800001 + i, 3'b000, 1'b0, 1'b0, 1'b0);
    check("full_level", 64'(level), 64'(DEPTH));
    check("full_in_ready", 64'(in_ready), 64'd0);
    cyc(1'b1, 32'h40000000, 3'b000, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h40000000, 3'b000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 3'b000, 1'b1, 1'b0, 1'b0);
    check("freed_in_ready", 64'(in_ready), 64'd1);
    drain();

    // Steady push+pop at level 2 across pointer wrap.
    cyc(1'b1, 32'h00000100, 3'b000, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00000101, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h00000102 + i, 3'b000, 1'b1, 1'b0, 1'b0);
    check("stream_level", 64'(level), 64'd2);
    check("stream_head", 64'(out_result), 64'h00000108);
    drain();

    // Exception flags pass through bit-exact and accumulate.
    cyc(1'b1, 32'h7F800000, 3'b010, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h7FC00000, 3'b100, 1'b0, 1'b0, 1'b0);
    check("sticky_ovf_inv", 64'(sticky_flags), 64'b110);
    check("head_flags", 64'(out_flags), 64'b010);
    drain();
    cyc(1'b1, 32'h00000001, 3'b001, 1'b0, 1'b1, 1'b0);
    check("clear_and_push", 64'(sticky_flags), 64'b001);
    drain();

    // Mid-stream reset.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hABCD0000 + i, 3'b111, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b1);
    check("rst_level", 64'(level), 64'd0);
    check("rst_out", 64'(out_result), 64'd0);
    cyc(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0);

    // Overflow events saturate the counter (when present) and clear.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h7F800000, 3'b010, 1'b1, 1'b0, 1'b0);
`ifdef FP_MUL_FLAG_COUNTERS_EN
    check("ovf_count_sat", 64'(overflow_count), 64'(CMAX));
`endif
    cyc(1'b0, '0, 3'b000, 1'b1, 1'b1, 1'b0);
`ifdef FP_MUL_FLAG_COUNTERS_EN
    check("ovf_count_clr", 64'(overflow_count), 64'd0);
`endif
    drain();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic v, r, clr, rs;
      logic [2:0] f;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      cyc(v, $urandom, f, r, clr, rs);
    end
    cyc(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
